// File: rtl/capture.sv
// Input-capture peripheral: prescaled timebase plus per-input edge detectors that
// push {timestamp, rise mask, fall mask} into a FIFO. Optional irq via CAPTURE_IRQ_EN.
module capture #(
    parameter int WIDTH = 32,
    parameter int NIN   = 4,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    input  logic             cs,
    output logic [WIDTH-1:0] dout,
`ifdef CAPTURE_IRQ_EN
    output logic             irq,
`endif
    input  logic [NIN-1:0]   cin
);
    localparam int DEPTH = 1 << AW;
    localparam int EW    = WIDTH + 2 * NIN;

    logic [WIDTH-1:0] pre, tcnt, precnt;
    logic [NIN-1:0]   rise_en, fall_en, s1, s2, s3, rise, fall;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             ovf, en, tick, we, empty, full;
    logic             wr_pre, wr_time, wr_ctrl, wr_stat, wr_pop, clr;
    logic             push_req, do_push, do_pop, ovf_set;
    logic [WIDTH-1:0] ctrl_rd, stat_rd, hsrc_rd, htime_rd;
    logic             unused_addr;
`ifdef CAPTURE_IRQ_EN
    logic             ie;
`endif

    assign unused_addr = ^addr[WIDTH-1:4];

    assign we      = cs & wen;
    assign wr_pre  = we && addr[3:0] == 4'd0;
    assign wr_time = we && addr[3:0] == 4'd1;
    assign wr_ctrl = we && addr[3:0] == 4'd2;
    assign wr_stat = we && addr[3:0] == 4'd3;
    assign wr_pop  = we && addr[3:0] == 4'd5;
    assign clr     = wr_ctrl & din[16];

    assign en   = |pre;
    assign tick = en && (precnt == pre);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre    <= '0;
            precnt <= '0;
            tcnt   <= '0;
        end else begin
            if (wr_pre) begin
                pre    <= din;
                precnt <= '0;
            end else if (tick) begin
                precnt <= '0;
            end else if (en) begin
                precnt <= precnt + WIDTH'(1);
            end
            // A TIME write takes priority over a coincident tick
            if (wr_time)   tcnt <= din;
            else if (tick) tcnt <= tcnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en <= '0;
            fall_en <= '0;
`ifdef CAPTURE_IRQ_EN
            ie      <= 1'b0;
`endif
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            if (wr_ctrl) begin
                rise_en <= din[NIN-1:0];
                fall_en <= din[8 +: NIN];
`ifdef CAPTURE_IRQ_EN
                ie      <= din[17];
`endif
            end
            s1 <= cin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3 & rise_en;
    assign fall     = ~s2 & s3 & fall_en;
    assign push_req = |rise | |fall;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = wr_pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push = push_req & (~full | do_pop);
    assign ovf_set = push_req & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (ovf_set)      ovf <= 1'b1;
            else if (wr_stat) ovf <= 1'b0;
            if (clr) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (do_push) wptr <= wptr + AW'(1);
                if (do_pop)  rptr <= rptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + (AW+1)'(1);
                    2'b01:   cnt <= cnt - (AW+1)'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= {tcnt, rise, fall};
    end

    assign head = mem[rptr];

`ifdef CAPTURE_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= ie & (~empty | ovf);
    end
`endif

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[NIN-1:0]     = rise_en;
        ctrl_rd[8 +: NIN]    = fall_en;
`ifdef CAPTURE_IRQ_EN
        ctrl_rd[17]          = ie;
`endif
        stat_rd              = '0;
        stat_rd[AW:0]        = cnt;
        stat_rd[16]          = empty;
        stat_rd[17]          = full;
        stat_rd[18]          = ovf;
        hsrc_rd              = '0;
        htime_rd             = '0;
        if (!empty) begin
            hsrc_rd[NIN-1:0]  = head[2*NIN-1:NIN];
            hsrc_rd[8 +: NIN] = head[NIN-1:0];
            htime_rd          = head[EW-1 -: WIDTH];
        end
        case (addr[3:0])
            4'd0:    dout = pre;
            4'd1:    dout = tcnt;
            4'd2:    dout = ctrl_rd;
            4'd3:    dout = stat_rd;
            4'd4:    dout = htime_rd;
            4'd5:    dout = hsrc_rd;
            default: dout = '0;
        endcase
    end
endmodule

// File: tb/tb_capture.sv
// Scoreboard bench for capture: stimulus queues expected read/irq values, a negedge
// monitor pops and compares them against the DUT.
module tb_capture;
    logic        clk = 1'b0;
    logic        reset, wen, cs;
    logic [31:0] addr, din, dout;
    logic [3:0]  cin;
    logic        irq_w;

    always #5 clk = ~clk;

`ifdef CAPTURE_IRQ_EN
    logic irq;
    assign irq_w = irq;
    capture dut (.clk(clk), .reset(reset), .addr(addr), .din(din), .wen(wen), .cs(cs),
                 .dout(dout), .irq(irq), .cin(cin));
`else
    assign irq_w = 1'b0;
    capture dut (.clk(clk), .reset(reset), .addr(addr), .din(din), .wen(wen), .cs(cs),
                 .dout(dout), .cin(cin));
`endif

    int          checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    bit          sel_q[$];
    string       name_q[$];
    bit          mon_vld = 1'b0;
    logic [31:0] m_exp, m_got;
    bit          m_sel;
    string       m_name;

    always @(negedge clk) begin
        if (mon_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow got=none expected=entry");
            end else begin
                m_exp  = exp_q.pop_front();
                m_sel  = sel_q.pop_front();
                m_name = name_q.pop_front();
                m_got  = m_sel ? {31'b0, irq_w} : dout;
                if (m_got !== m_exp) begin
                    failures++;
                    $display("FAIL %s got=0x%08h expected=0x%08h", m_name, m_got, m_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = {28'b0, a}; din = d;
        @(posedge clk); #1;
        cs = 1'b0; wen = 1'b0;
    endtask

    task automatic expect_val(input bit s, input logic [3:0] a, input logic [31:0] e, input string n);
        cs = 1'b1; wen = 1'b0; addr = {28'b0, a};
        exp_q.push_back(e); sel_q.push_back(s); name_q.push_back(n);
        mon_vld = 1'b1;
        @(posedge clk); #1;
        mon_vld = 1'b0; cs = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        expect_val(1'b0, a, e, n);
    endtask

    task automatic chk_irq(input logic e, input string n);
        expect_val(1'b1, 4'd0, {31'b0, e}, n);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = '0; din = '0; cin = '0;
        tick(3);
        reset = 1'b0;
        rd(3, 32'h0001_0000, "rst_stat");
        rd(4, 32'h0, "rst_htime");
        rd(5, 32'h0, "rst_hsrc");
        rd(1, 32'h0, "rst_time");
        rd(2, 32'h0, "rst_ctrl");

        // Single rising edge with a running timebase (TIME steps every 2 clks)
        wr(2, 32'h1);
        wr(1, 32'h0);
        wr(0, 32'h1);
        cin = 4'b0001;
        rd(3, 32'h0001_0000, "lat_0");
        rd(3, 32'h0001_0000, "lat_1");
        rd(3, 32'h0001_0000, "lat_2");
        rd(3, 32'h0000_0001, "lat_3");
        rd(5, 32'h1, "hsrc_single");
        rd(4, 32'h1, "htime_single");
        wr(0, 32'h0);
        wr(5, 32'h0);
        rd(3, 32'h0001_0000, "pop_single");

        // Simultaneous edges share one entry; frozen timebase
        wr(1, 32'h100);
        cin = 4'b0000;
        tick(4);
        wr(2, 32'h0F0F);
        cin = 4'b0101;
        tick(4);
        rd(3, 32'h1, "multi_cnt");
        rd(5, 32'h5, "multi_rise");
        rd(4, 32'h100, "multi_time");
        cin = 4'b0000;
        tick(4);
        rd(3, 32'h2, "multi_cnt2");
        wr(5, 32'h0);
        rd(5, 32'h500, "multi_fall");
        rd(4, 32'h100, "multi_time2");
        wr(5, 32'h0);
        rd(3, 32'h0001_0000, "multi_empty");
        wr(5, 32'h0);
        rd(3, 32'h0001_0000, "pop_while_empty");
        rd(5, 32'h0, "hsrc_empty");

        // Fill, overflow, OVF clear, pop+push while full
        for (int i = 0; i < 8; i++) begin
            wr(1, 32'h200 + i);
            cin[1] = ~cin[1];
            tick(4);
        end
        rd(3, 32'h0002_0008, "full");
        cin[1] = 1'b1;
        tick(4);
        rd(3, 32'h0006_0008, "overflow");
        rd(4, 32'h200, "ovf_head_time");
        rd(5, 32'h2, "ovf_head_src");
        wr(3, 32'h0);
        rd(3, 32'h0002_0008, "ovf_clear");
        cin[1] = 1'b0;
        tick(2);
        wr(5, 32'h0);
        rd(3, 32'h0002_0008, "pushpop_full");
        for (int i = 1; i < 8; i++) begin
            rd(4, 32'h200 + i, "drain_time");
            rd(5, (i % 2) ? 32'h200 : 32'h2, "drain_src");
            wr(5, 32'h0);
        end
        rd(4, 32'h207, "last_time");
        rd(5, 32'h200, "last_src");
        wr(5, 32'h0);
        rd(3, 32'h0001_0000, "drained");

        // CLR and CTRL readback
        cin[3] = 1'b1;
        tick(4);
        rd(3, 32'h1, "pre_clr");
        wr(2, 32'h0001_0F0F);
        rd(3, 32'h0001_0000, "clr");
        rd(2, 32'h0F0F, "ctrl_no_clr");
        wr(2, 32'hFFFF_FFFF);
`ifdef CAPTURE_IRQ_EN
        rd(2, 32'h0002_0F0F, "ctrl_all");
`else
        rd(2, 32'h0000_0F0F, "ctrl_all");
`endif
        wr(2, 32'h0F0F);

        // Unmapped addresses
        wr(9, 32'h1234);
        rd(9, 32'h0, "unmapped_9");
        rd(7, 32'h0, "unmapped_7");

        // TIME wrap and TIME write on a tick cycle
        wr(1, 32'hFFFF_FFFF);
        wr(0, 32'h1);
        rd(1, 32'hFFFF_FFFF, "wrap_0");
        rd(1, 32'hFFFF_FFFF, "wrap_1");
        rd(1, 32'h0, "wrap_2");
        wr(1, 32'h1234);
        rd(1, 32'h1234, "time_wr_on_tick");
        rd(0, 32'h1, "pre_rd");
        wr(0, 32'h0);

`ifdef CAPTURE_IRQ_EN
        wr(2, 32'h0002_0F0F);
        cin[2] = 1'b1;
        tick(3);
        chk_irq(1'b0, "irq_before");
        chk_irq(1'b1, "irq_set");
        wr(5, 32'h0);
        chk_irq(1'b1, "irq_hold");
        chk_irq(1'b0, "irq_pop");
        cin[2] = 1'b0;
        tick(4);
        chk_irq(1'b1, "irq_set2");
        cin[2] = 1'b1;
        tick(2);
        wr(2, 32'h0003_0F0F);
        rd(3, 32'h0001_0000, "clr_with_push");
        chk_irq(1'b0, "irq_clr");
`endif

        // Reset mid-operation
        cin = 4'b0000;
        tick(4);
        rd(3, 32'h1, "pre_reset");
        wr(1, 32'h5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(3, 32'h0001_0000, "rst_mid_stat");
        rd(1, 32'h0, "rst_mid_time");
        rd(2, 32'h0, "rst_mid_ctrl");

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/capture.md
Name: capture

Overview:
- Memory-mapped input-capture peripheral; the counterpart of the clock/timer peripheral. The timer block produces time-based counts and events; this block does the opposite and timestamps external input edges.
- Contains a prescaled free-running timebase and per-input edge detectors. Detected edges push {timestamp, edge masks} into a FIFO, which the CPU drains over the same cs/wen/addr/din/dout slave bus.

Parameters:
- WIDTH, 32, data and timestamp width.
- NIN, 4, number of capture inputs (1..8).
- AW, 3, log2 of FIFO depth (DEPTH = 2^AW = 8).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  WIDTH  register address; only addr[3:0] is decoded.
- din  input  WIDTH  write data.
- wen  input  1  write enable; qualified by cs.
- cs  input  1  chip select.
- dout  output  WIDTH  read data; combinational from addr; unmapped addresses read 0.
- cin  input  NIN  asynchronous capture inputs.

Behaviour:
- Register map (addr[3:0]):
  - 0 PRE, rw.
  - 1 TIME, rw.
  - 2 CTRL, rw.
  - 3 STAT, ro; any write clears OVF.
  - 4 HTIME, ro: head timestamp.
  - 5 HSRC, ro: head source. Any write pops the FIFO.
  - 6..15 read 0; writes to them are ignored.
- Reset: PRE, TIME, CTRL, prescaler count, sync flops, FIFO pointers, count and OVF all go to 0. dout follows addr, so reading STAT right after reset gives EMPTY=1 and all other bits 0.
- Timebase:
  - en = |PRE. The prescaler count increments while en is set.
  - tick = en & (precnt == PRE); on tick, precnt goes to 0 and TIME increments, wrapping from 2^WIDTH-1 to 0.
  - A write to PRE loads PRE and zeroes precnt.
  - A write to TIME loads din. If a TIME write coincides with a tick, the write wins.
  - PRE=0 stops the timebase.
- CTRL:
  - bits[NIN-1:0] rising-edge enables.
  - bits[8+NIN-1:8] falling-edge enables.
  - bit16 CLR: a write with bit16=1 empties the FIFO. CLR is not stored and reads 0.
  - All other bits read 0.
- Input path:
  - Each cin bit passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - rise[i] = s2 & ~s3 & CTRL[i]; fall[i] = ~s2 & s3 & CTRL[8+i].
  - Latency: a cin change set up before edge k appears in STAT.CNT after edge k+2.
- Push:
  - One push per cycle when |rise or |fall.
  - Entry = {TIME value in the detect cycle (pre-update), rise mask, fall mask}.
  - Simultaneous edges on several inputs share one entry.
- HSRC layout: bits[NIN-1:0] rise mask, bits[8+NIN-1:8] fall mask. Reads 0 when the FIFO is empty; HTIME also reads 0 when empty.
- STAT layout:
  - bits[AW:0] CNT (0..DEPTH).
  - bit16 EMPTY; bit17 FULL.
  - bit18 OVF, sticky.
- FIFO boundaries:
  - Push while full and no pop: entry dropped, OVF=1.
  - Push and pop in the same cycle while full: both happen, CNT unchanged, no OVF.
  - Pop while empty: ignored.
  - Push and pop while empty: push only.
  - CLR concurrent with push or pop: CLR wins, CNT=0. OVF is unaffected by CLR.
  - A STAT write concurrent with an overflow: OVF ends at 1 (set wins).
- Pointer wrap is modulo DEPTH.
- Reset mid-operation discards FIFO contents and pending synchronizer state.

Optional Feature:
- Macro: CAPTURE_IRQ_EN.
- Defined:
  - Adds port irq (output, 1 bit) and CTRL bit17 IE (rw).
  - irq = IE & (~EMPTY | OVF); registered, updated each clk, reset 0.
- Undefined: no irq port, CTRL bit17 reads 0, no other change.

Test Plan:
- Reset, then read addr 3 -> dout = 0x00010000 (EMPTY); addr 4 and addr 5 -> 0.
- PRE=1, TIME=0, CTRL=0x1, cin[0] 0->1 -> entry after 3 clks, CNT=1. HSRC=0x1; HTIME equals TIME at detect (TIME increments every 2 clks).
- CTRL=0x0F0F, cin 0000->0101 in one cycle -> single entry, HSRC=0x5. Then cin ->0000 -> second entry HSRC=0x500. Pop twice -> EMPTY=1.
- Fill 8 entries, then a 9th edge -> CNT=8, FULL=1, OVF=1, first entry intact. Write STAT -> OVF=0. Pop concurrent with a new edge while full -> CNT stays 8, OVF stays 0.
- TIME write 0xFFFFFFFF with PRE=1 -> wraps to 0 after the next tick. A TIME write landing on a tick cycle -> TIME = din.
- With CAPTURE_IRQ_EN: IE=1, one edge -> irq=1 one clk after the push. Pop -> irq=0. CLR during a push -> CNT=0, irq drops.
